// File: rtl/lc3_ctrl_pkg.sv
// Shared opcode encodings, memory-phase codes and controller state type for
// the LC-3 pipeline controller.
package lc3_ctrl_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] MEM_IND_READ = 2'd0;
  localparam logic [1:0] MEM_READ     = 2'd1;
  localparam logic [1:0] MEM_WRITE    = 2'd2;
  localparam logic [1:0] MEM_IDLE     = 2'd3;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_RUN,
    ST_MEM,
    ST_CTRL_WAIT,
    ST_BR_RESOLVE
  } ctrl_state_t;

  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic logic is_ctrl(input logic [3:0] op);
    return (op == OP_BR) || (op == OP_JMP);
  endfunction

  function automatic logic is_indirect(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/lc3_bypass_unit.sv
// Combinational forwarding decision: route the execute-stage ALU result to
// decode source 1 and/or source 2 when the register numbers collide.
module lc3_bypass_unit
  import lc3_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [15:0] ir_exec,
  input  logic        in_run,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2
);

  logic [3:0] dec_op;
  logic [3:0] exec_op;
  logic       exec_alu;
  logic       sr1_user;
  logic       sr2_user;
  logic       unused_fields;

  assign dec_op  = ir[15:12];
  assign exec_op = ir_exec[15:12];

  // STR reads its base register through the source-1 port.
  always_comb begin
    exec_alu     = in_run && is_alu(exec_op);
    sr1_user     = is_alu(dec_op) || (dec_op == OP_STR);
    sr2_user     = ((dec_op == OP_ADD) || (dec_op == OP_AND)) && !ir[5];
    bypass_alu_1 = exec_alu && sr1_user && (ir[8:6] == ir_exec[11:9]);
    bypass_alu_2 = exec_alu && sr2_user && (ir[2:0] == ir_exec[11:9]);
  end

  assign unused_fields = ^{ir[11:9], ir[4:3], ir_exec[8:0]};

endmodule

// File: rtl/lc3_controller.sv
// LC-3 pipeline controller: stage enables, memory-phase sequencing, branch
// resolution and ALU forwarding.
//
//   state         | meaning
//   FILL          | pipeline filling after reset, stages switch on one by one
//   RUN           | normal flow, watching for memory and control instructions
//   MEM           | pipeline frozen while data memory phases complete
//   CTRL_WAIT     | fetch frozen for two cycles while branch reaches execute
//   BR_RESOLVE    | one cycle: redirect PC if taken, fetch resumes
module lc3_controller
  import lc3_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        complete_data,
  input  logic        complete_instr,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2
);

  ctrl_state_t state;
  ctrl_state_t state_next;

  logic [1:0] fill_cnt;
  logic       wait_cnt;
  logic       mem_load;
  logic       mem_indirect;
  logic       ind_done;
  logic       ctrl_jmp;

  logic       mem_hit;
  logic       ctrl_hit;
  logic       ind_phase;
  logic       in_run;

  // A memory instruction in execute wins over a control instruction in decode.
  assign mem_hit   = is_load(IR_Exec[15:12]) || is_store(IR_Exec[15:12]);
  assign ctrl_hit  = is_ctrl(IR[15:12]) && !mem_hit;
  assign ind_phase = mem_indirect && !ind_done;
  assign in_run    = (state == ST_RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_FILL;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fill_cnt     <= 2'd0;
      wait_cnt     <= 1'b0;
      mem_load     <= 1'b0;
      mem_indirect <= 1'b0;
      ind_done     <= 1'b0;
      ctrl_jmp     <= 1'b0;
    end else begin
      if (state == ST_FILL) begin
        fill_cnt <= fill_cnt + 2'd1;
      end else begin
        fill_cnt <= 2'd0;
      end

      if (state == ST_CTRL_WAIT) begin
        wait_cnt <= ~wait_cnt;
      end else begin
        wait_cnt <= 1'b0;
      end

      // IR_Exec is frozen during MEM, but the phase plan is latched anyway
      // so the sequence cannot change underneath itself.
      if (in_run && mem_hit) begin
        mem_load     <= is_load(IR_Exec[15:12]);
        mem_indirect <= is_indirect(IR_Exec[15:12]);
        ind_done     <= 1'b0;
      end else if ((state == ST_MEM) && complete_data && ind_phase) begin
        ind_done <= 1'b1;
      end

      // Decode keeps advancing during CTRL_WAIT, so remember JMP vs BR now.
      if (in_run && ctrl_hit) begin
        ctrl_jmp <= (IR[15:12] == OP_JMP);
      end
    end
  end

  always_comb begin
    state_next       = state;
    enable_updatePC  = 1'b0;
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    br_taken         = 1'b0;
    mem_state        = MEM_IDLE;

    case (state)
      ST_FILL: begin
        enable_updatePC  = 1'b1;
        enable_fetch     = 1'b1;
        enable_decode    = (fill_cnt != 2'd0);
        enable_execute   = fill_cnt[1];
        enable_writeback = (fill_cnt == 2'd3);
        if (fill_cnt == 2'd3) begin
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        enable_decode    = 1'b1;
        enable_execute   = 1'b1;
        enable_writeback = 1'b1;
        // Fetch stops already in the detect cycle so no wrong-path word is taken.
        enable_updatePC  = complete_instr && !ctrl_hit;
        enable_fetch     = complete_instr && !ctrl_hit;
        if (mem_hit) begin
          state_next = ST_MEM;
        end else if (ctrl_hit) begin
          state_next = ST_CTRL_WAIT;
        end
      end

      ST_MEM: begin
        if (ind_phase) begin
          mem_state = MEM_IND_READ;
        end else if (mem_load) begin
          mem_state = MEM_READ;
        end else begin
          mem_state = MEM_WRITE;
        end
        if (complete_data && !ind_phase) begin
          enable_writeback = mem_load;
          state_next       = ST_RUN;
        end
      end

      ST_CTRL_WAIT: begin
        enable_decode    = 1'b1;
        enable_execute   = 1'b1;
        enable_writeback = 1'b1;
        if (wait_cnt) begin
          state_next = ST_BR_RESOLVE;
        end
      end

      ST_BR_RESOLVE: begin
        enable_updatePC  = 1'b1;
        enable_fetch     = 1'b1;
        enable_decode    = 1'b1;
        enable_execute   = 1'b1;
        enable_writeback = 1'b1;
        br_taken         = ctrl_jmp || (|(NZP & psr));
        state_next       = ST_RUN;
      end

      default: begin
        state_next = ST_FILL;
      end
    endcase
  end

  lc3_bypass_unit u_bypass (
    .ir           (IR),
    .ir_exec      (IR_Exec),
    .in_run       (in_run),
    .bypass_alu_1 (bypass_alu_1),
    .bypass_alu_2 (bypass_alu_2)
  );

endmodule

// File: tb/tb_lc3_controller.sv
// Randomized directed-sequence bench for lc3_controller with a transaction-level
// expectation model of enables, memory phases, branch outcome and forwarding.
module tb_lc3_controller;

  logic        clock;
  logic        reset_n;
  logic        complete_data;
  logic        complete_instr;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
  logic [2:0]  psr;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic [1:0]  mem_state;
  logic        bypass_alu_1;
  logic        bypass_alu_2;

  logic [9:0]  vec;

  int n_cmp;
  int n_err;

  localparam logic [9:0] ALL     = 10'h3FF;
  localparam logic [9:0] NO_WB   = 10'h3DF;
  localparam logic [9:0] BR_MASK = 10'h31F;
  localparam logic [15:0] NEUTRAL = 16'hD000;

  logic [3:0] exec_safe [10] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd8, 4'd9, 4'd12, 4'd13, 4'd14, 4'd15};
  logic [3:0] ir_safe   [14] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
                                 4'd11, 4'd13, 4'd14, 4'd15};
  logic [3:0] ldst_ops  [6]  = '{4'd2, 4'd3, 4'd6, 4'd7, 4'd10, 4'd11};

  lc3_controller dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .complete_data    (complete_data),
    .complete_instr   (complete_instr),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .NZP              (NZP),
    .psr              (psr),
    .enable_updatePC  (enable_updatePC),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .br_taken         (br_taken),
    .mem_state        (mem_state),
    .bypass_alu_1     (bypass_alu_1),
    .bypass_alu_2     (bypass_alu_2)
  );

  assign vec = {enable_updatePC, enable_fetch, enable_decode, enable_execute,
                enable_writeback, br_taken, mem_state, bypass_alu_1, bypass_alu_2};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [9:0] mk(input logic upc, input logic f, input logic d,
                                    input logic e, input logic w, input logic br,
                                    input logic [1:0] ms, input logic b1, input logic b2);
    return {upc, f, d, e, w, br, ms, b1, b2};
  endfunction

  // Expected outputs for one RUN cycle, straight from the opcode-class rules.
  function automatic logic [9:0] run_vec(input logic [15:0] ir, input logic [15:0] ire,
                                         input logic ci);
    logic [3:0] op;
    logic [3:0] eop;
    logic exec_alu, ldst, ctrl, b1, b2, f;
    op       = ir[15:12];
    eop      = ire[15:12];
    exec_alu = eop inside {4'd1, 4'd5, 4'd9, 4'd14};
    ldst     = eop inside {4'd2, 4'd3, 4'd6, 4'd7, 4'd10, 4'd11};
    ctrl     = (op == 4'd0 || op == 4'd12) && !ldst;
    b1 = exec_alu && ((op inside {4'd1, 4'd5, 4'd9, 4'd14}) || op == 4'd7) && (ir[8:6] == ire[11:9]);
    b2 = exec_alu && (op == 4'd1 || op == 4'd5) && !ir[5] && (ir[2:0] == ire[11:9]);
    f  = ci && !ctrl;
    return mk(f, f, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, b1, b2);
  endfunction

  function automatic logic [9:0] reset_vec();
    return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
  endfunction

  function automatic logic [9:0] fill_vec(input int k);
    return mk(1'b1, 1'b1, k >= 1, k >= 2, k == 3, 1'b0, 2'd3, 1'b0, 1'b0);
  endfunction

  function automatic logic [15:0] rand_with_op(input logic [3:0] op);
    logic [15:0] r;
    r        = 16'($urandom);
    r[15:12] = op;
    r[11:9]  = 3'($urandom_range(0, 3));
    r[8:6]   = 3'($urandom_range(0, 3));
    r[2:0]   = 3'($urandom_range(0, 3));
    return r;
  endfunction

  function automatic logic [15:0] rand_exec();
    return rand_with_op(exec_safe[$urandom_range(0, 9)]);
  endfunction

  function automatic logic [15:0] rand_ir();
    return rand_with_op(ir_safe[$urandom_range(0, 13)]);
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp,
                       input logic [9:0] mask);
    n_cmp++;
    assert ((obs & mask) === (exp & mask)) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs & mask, exp & mask);
    end
  endtask

  task automatic sample(input string tag, input logic [9:0] exp, input logic [9:0] mask);
    @(negedge clock);
    check(tag, vec, exp, mask);
    @(posedge clock);
    #1;
  endtask

  task automatic fill_seq();
    for (int k = 0; k < 4; k++) begin
      sample("fill", fill_vec(k), ALL);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      IR             = rand_ir();
      IR_Exec        = rand_exec();
      complete_instr = 1'($urandom_range(0, 1));
      complete_data  = 1'($urandom_range(0, 1));
      NZP            = 3'($urandom);
      psr            = 3'($urandom);
      sample("run", run_vec(IR, IR_Exec, complete_instr), ALL);
    end
  endtask

  task automatic mem_txn(input logic [15:0] instr, input int d1, input int d2,
                         input logic [15:0] ir_val);
    logic [3:0] op;
    logic is_ld, indirect;
    logic [1:0] final_ms;
    op       = instr[15:12];
    is_ld    = op inside {4'd2, 4'd6, 4'd10};
    indirect = (op == 4'd10) || (op == 4'd11);
    final_ms = is_ld ? 2'd1 : 2'd2;
    IR             = ir_val;
    IR_Exec        = instr;
    complete_data  = 1'b0;
    complete_instr = 1'b1;
    sample("mem_enter", run_vec(IR, IR_Exec, 1'b1), ALL);
    if (indirect) begin
      for (int i = 0; i < d1; i++) begin
        sample("mem_ind_wait", mk(0, 0, 0, 0, 0, 0, 2'd0, 0, 0), ALL);
      end
      complete_data = 1'b1;
      sample("mem_ind_done", mk(0, 0, 0, 0, 0, 0, 2'd0, 0, 0), ALL);
      complete_data = 1'b0;
    end
    for (int i = 0; i < d2; i++) begin
      sample("mem_wait", mk(0, 0, 0, 0, 0, 0, final_ms, 0, 0), ALL);
    end
    complete_data = 1'b1;
    sample("mem_last", mk(0, 0, 0, 0, is_ld, 0, final_ms, 0, 0), ALL);
    complete_data = 1'b0;
    IR_Exec       = rand_exec();
  endtask

  task automatic ctrl_txn(input logic [15:0] instr, input logic [2:0] nzp_v,
                          input logic [2:0] psr_v, input logic ci);
    logic taken;
    taken          = (instr[15:12] == 4'd12) || (instr[15:12] == 4'd0 && |(nzp_v & psr_v));
    IR             = instr;
    IR_Exec        = rand_exec();
    complete_instr = ci;
    complete_data  = 1'b0;
    sample("ctrl_detect", run_vec(IR, IR_Exec, ci), ALL);
    IR = rand_ir();
    sample("ctrl_wait1", mk(0, 0, 1, 1, 0, 0, 2'd3, 0, 0), NO_WB);
    sample("ctrl_wait2", mk(0, 0, 1, 1, 0, 0, 2'd3, 0, 0), NO_WB);
    NZP = nzp_v;
    psr = psr_v;
    sample("br_resolve", mk(1, 1, 0, 0, 0, taken, 2'd3, 0, 0), BR_MASK);
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset_n        = 1'b1;
    complete_data  = 1'b0;
    complete_instr = 1'b1;
    IR             = NEUTRAL;
    IR_Exec        = NEUTRAL;
    NZP            = 3'd0;
    psr            = 3'd0;
    #2 reset_n = 1'b0;
    sample("reset", reset_vec(), ALL);
    reset_n = 1'b1;
    fill_seq();
    sample("run_first", run_vec(IR, IR_Exec, 1'b1), ALL);
    run_cycles(20);

    IR_Exec = 16'h1262;
    IR      = 16'h1441;
    complete_instr = 1'b1;
    sample("bypass_both", run_vec(IR, IR_Exec, 1'b1), ALL);
    check("bypass_both_lit", vec, mk(1, 1, 1, 1, 1, 0, 2'd3, 1, 1), ALL);
    IR      = NEUTRAL;
    IR_Exec = NEUTRAL;

    mem_txn(16'hA401, 1, 1, NEUTRAL);
    ctrl_txn(16'h0403, 3'b010, 3'b010, 1'b1);
    ctrl_txn(16'h0403, 3'b010, 3'b100, 1'b1);
    ctrl_txn(16'hC1C0, 3'b000, 3'b000, 1'b1);

    mem_txn(16'h7283, 0, 2, 16'hC1C0);
    ctrl_txn(16'hC1C0, 3'($urandom), 3'($urandom), 1'b1);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0: run_cycles($urandom_range(1, 4));
        1: mem_txn(rand_with_op(ldst_ops[$urandom_range(0, 5)]),
                   $urandom_range(0, 3), $urandom_range(0, 3), rand_ir());
        default: ctrl_txn(rand_with_op(($urandom_range(0, 1) == 0) ? 4'd0 : 4'd12),
                          3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));
      endcase
    end

    // Reset dropped while STI is in its write phase.
    IR             = NEUTRAL;
    IR_Exec        = 16'hB401;
    complete_instr = 1'b1;
    complete_data  = 1'b0;
    sample("sti_enter", run_vec(IR, IR_Exec, 1'b1), ALL);
    complete_data = 1'b1;
    sample("sti_ind", mk(0, 0, 0, 0, 0, 0, 2'd0, 0, 0), ALL);
    complete_data = 1'b0;
    sample("sti_write", mk(0, 0, 0, 0, 0, 0, 2'd2, 0, 0), ALL);
    #2 reset_n = 1'b0;
    #1 check("reset_async_mem", vec, reset_vec(), ALL);
    IR_Exec = NEUTRAL;
    sample("reset_held_mem", reset_vec(), ALL);
    reset_n = 1'b1;
    fill_seq();
    sample("run_after_mem_reset", run_vec(IR, IR_Exec, 1'b1), ALL);

    // Reset dropped in the middle of CTRL_WAIT for a branch that would be taken.
    IR  = 16'h0E05;
    NZP = 3'b111;
    psr = 3'b010;
    sample("ctrl2_detect", run_vec(IR, IR_Exec, 1'b1), ALL);
    IR = NEUTRAL;
    sample("ctrl2_wait1", mk(0, 0, 1, 1, 0, 0, 2'd3, 0, 0), NO_WB);
    #2 reset_n = 1'b0;
    #1 check("reset_async_ctrl", vec, reset_vec(), ALL);
    sample("reset_held_ctrl", reset_vec(), ALL);
    reset_n = 1'b1;
    fill_seq();
    sample("run_after_ctrl_reset", run_vec(IR, IR_Exec, 1'b1), ALL);
    run_cycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lc3_controller.md
LC3_CONTROLLER -- requirements
Module: lc3_controller

Interface
REQ-001 SHALL: clock  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL: complete_data  in  1  data-memory access done this cycle.
REQ-004 SHALL: complete_instr  in  1  instruction-memory fetch done this cycle.
REQ-005 SHALL: IR  in  16  instruction in decode stage (decode Instr_Reg).
REQ-006 SHALL: IR_Exec  in  16  instruction in execute stage.
REQ-007 SHALL: NZP  in  3  condition mask from execute (BR n,z,p bits).
REQ-008 SHALL: psr  in  3  current processor status N,Z,P.
REQ-009 SHALL: enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback  out  1 each  stage enables (enable_decode drives decode en_de).
REQ-010 SHALL: br_taken  out  1  redirect PC to branch/jump target.
REQ-011 SHALL: mem_state  out  2  0=indirect-read, 1=read, 2=write, 3=idle.
REQ-012 SHALL: bypass_alu_1, bypass_alu_2  out  1 each  forward execute ALU result to source 1 / source 2.

Function
REQ-013 SHALL: Opcode classes: ALU = ADD 0001, AND 0101, NOT 1001, LEA 1110; LOAD = LD 0010, LDR 0110, LDI 1010; STORE = ST 0011, STR 0111, STI 1011; CTRL = BR 0000, JMP 1100.
REQ-014 SHALL: FSM states FILL, RUN, MEM, CTRL_WAIT, BR_RESOLVE.
REQ-015 SHALL: FILL: fetch/updatePC = 1; decode rises 1 cycle after reset release, execute after 2, writeback after 3 (2-bit fill counter); then RUN.
REQ-016 SHALL: RUN with IR_Exec[15:12] in LOAD/STORE -> MEM next cycle; updatePC, fetch, decode, execute, writeback = 0 while in MEM.
REQ-017 SHALL: MEM sequence: LD/LDR 1; LDI 0 then 1; ST/STR 2; STI 0 then 2; each mem_state value held until complete_data = 1, then advance.
REQ-018 SHALL: last MEM phase with complete_data = 1 -> RUN; for LOAD, enable_writeback = 1 in that same cycle; for STORE writeback stays 0.
REQ-019 SHALL: RUN with IR[15:12] in CTRL -> enable_updatePC and enable_fetch = 0 next cycle; state CTRL_WAIT for exactly 2 cycles (decode/execute remain enabled), then BR_RESOLVE.
REQ-020 SHALL: BR_RESOLVE lasts 1 cycle: br_taken = 1 iff JMP, or BR with |(NZP & psr) = 1; enable_updatePC = 1, enable_fetch = 1; then RUN.
REQ-021 SHALL: MEM has priority over CTRL detection on the same cycle; CTRL re-evaluated on return to RUN.
REQ-022 SHALL: enable_fetch and enable_updatePC additionally forced to 0 while complete_instr = 0 in RUN.
REQ-023 SHALL: bypass_alu_1 = 1 (combinational) when IR_Exec is ALU, IR is ALU or STORE-base user, and IR[8:6] == IR_Exec[11:9].
REQ-024 SHALL: bypass_alu_2 = 1 when IR_Exec is ALU, IR is ADD/AND with IR[5] = 0, and IR[2:0] == IR_Exec[11:9].
REQ-025 SHALL: bypass outputs = 0 in any state except RUN.
REQ-026 SHALL: br_taken never asserted outside BR_RESOLVE; mem_state = 3 outside MEM.

Reset
REQ-027 SHALL: reset_n low (asynchronously): state FILL, fill counter 0, enable_fetch = enable_updatePC = 1, enable_decode = enable_execute = enable_writeback = 0, br_taken = 0, mem_state = 3, bypasses = 0.
REQ-028 SHALL: reset asserted mid-MEM or mid-CTRL_WAIT aborts the sequence; no residual mem_state or br_taken after release.

Structure
REQ-029 SHALL: package lc3_ctrl_pkg holds opcode localparams, mem_state constants, ctrl_state_t enum.
REQ-030 SHALL: combinational forwarding in sub-module lc3_bypass_unit (IR, IR_Exec, state-in-RUN -> bypass_alu_1/2).

Verification
REQ-031 SHALL: release reset, complete_instr = 1, NOPs -> decode = 1 at cycle 1, execute at 2, writeback at 3.
REQ-032 SHALL: IR_Exec = LDI (0xA401), complete_data after 2 cycles each phase -> mem_state 0,0,1,1 then 3; writeback pulse on last cycle.
REQ-033 SHALL: IR = BRz (0x0403), NZP = 010, psr = 010 -> fetch low 3 cycles, br_taken = 1 for 1 cycle; psr = 100 -> br_taken stays 0.
REQ-034 SHALL: IR_Exec = ADD R1 (0x1262), IR = ADD R2,R1,R1 (0x1441) -> bypass_alu_1 = bypass_alu_2 = 1.
REQ-035 SHALL: reset_n low during STI write phase -> mem_state = 3, enables at reset values immediately.
REQ-036 SHALL: IR_Exec = STR and IR = JMP simultaneously -> MEM first, CTRL_WAIT entered after MEM completes.
